// File: rtl/main_decoder.sv
// -----------------------------------------------------------------------------
// main_decoder
//
// Purpose:
//   Main control decoder for a single-cycle MIPS-style datapath. The 6-bit
//   primary opcode (instruction bits [31:26]) is decoded combinationally and
//   every control signal is registered, so all outputs are flop outputs with
//   exactly one cycle of latency. There is no enable and no handshake: a new
//   opcode is accepted on every rising clock edge.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset; clears every output
//   Opcode    in   6  instruction bits [31:26]
//   regwrite  out  1  register-file write enable
//   regdest   out  1  destination select: 1 = rd, 0 = rt
//   alusrc    out  1  ALU operand B: 1 = sign-extended immediate, 0 = register
//   memtoreg  out  1  write-back select: 1 = data memory, 0 = ALU result
//   memwrite  out  1  data-memory write enable
//   branch    out  1  conditional branch (beq)
//   jump      out  1  unconditional jump
//   ALUOp     out  2  00 = add, 01 = subtract/compare, 10 = decode funct
//   illegal   out  1  opcode outside the supported set
// -----------------------------------------------------------------------------
module main_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    output logic       regwrite,
    output logic       regdest,
    output logic       alusrc,
    output logic       memtoreg,
    output logic       memwrite,
    output logic       branch,
    output logic       jump,
    output logic [1:0] ALUOp,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic       regdest;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Every field defaults to 0, so don't-care fields (regdest/memtoreg for
    // sw, everything but jump for j) come out as 0 without extra code.
    // The case uses exact matching: an opcode carrying X/Z bits matches no
    // item and lands in the default branch, which is a clean illegal decode
    // with no X reaching the flops.
    always_comb begin
        ctrl_d = '0;
        case (Opcode)
            OP_RTYPE: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.regdest  = 1'b1;
                ctrl_d.aluop    = ALU_FUNCT;
            end
            OP_LW: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memtoreg = 1'b1;
                ctrl_d.aluop    = ALU_ADD;
            end
            OP_SW: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
                ctrl_d.aluop    = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.aluop    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.aluop    = ALU_SUB;
            end
            OP_J: begin
                ctrl_d.jump     = 1'b1;
            end
            default: begin
                // Unsupported opcode: flag it and leave every state-changing
                // control (regwrite, memwrite, branch, jump) at 0.
                ctrl_d.illegal  = 1'b1;
            end
        endcase
    end

    // Reset clears everything, illegal included; the opcode present while
    // reset is held is simply never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign regwrite = ctrl_q.regwrite;
    assign regdest  = ctrl_q.regdest;
    assign alusrc   = ctrl_q.alusrc;
    assign memtoreg = ctrl_q.memtoreg;
    assign memwrite = ctrl_q.memwrite;
    assign branch   = ctrl_q.branch;
    assign jump     = ctrl_q.jump;
    assign ALUOp    = ctrl_q.aluop;
    assign illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_main_decoder.sv
// -----------------------------------------------------------------------------
// tb_main_decoder
//
// Directed bench for main_decoder. Expected control words are written out by
// hand from the decode table, packed in the order
//   {regwrite, regdest, alusrc, branch, memwrite, memtoreg, jump, ALUOp, illegal}
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge (or between edges for the asynchronous reset checks).
// -----------------------------------------------------------------------------
module tb_main_decoder;

    localparam logic [9:0] EXP_ZERO = 10'b0000000_00_0;
    localparam logic [9:0] EXP_R    = 10'b1100000_10_0;
    localparam logic [9:0] EXP_LW   = 10'b1010010_00_0;
    localparam logic [9:0] EXP_SW   = 10'b0010100_00_0;
    localparam logic [9:0] EXP_ADDI = 10'b1010000_00_0;
    localparam logic [9:0] EXP_BEQ  = 10'b0001000_01_0;
    localparam logic [9:0] EXP_J    = 10'b0000001_00_0;
    localparam logic [9:0] EXP_ILL  = 10'b0000000_00_1;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       regwrite;
    logic       regdest;
    logic       alusrc;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] ALUOp;
    logic       illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    main_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Opcode   (Opcode),
        .regwrite (regwrite),
        .regdest  (regdest),
        .alusrc   (alusrc),
        .memtoreg (memtoreg),
        .memwrite (memwrite),
        .branch   (branch),
        .jump     (jump),
        .ALUOp    (ALUOp),
        .illegal  (illegal)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {regwrite, regdest, alusrc, branch, memwrite, memtoreg, jump, ALUOp, illegal};
    endfunction

    // Compare the full control word, then the structural invariants that
    // must hold in every cycle regardless of opcode.
    task automatic check(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = observed();
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        tests_run++;
        assert ($countones({branch, jump, memwrite}) <= 1) else begin
            tests_failed++;
            $error("FAIL %s_onehot: observed branch/jump/memwrite %b expected at most one set",
                   tag, {branch, jump, memwrite});
        end
        tests_run++;
        assert (ALUOp !== 2'b11) else begin
            tests_failed++;
            $error("FAIL %s_aluop: observed ALUOp %b expected not 11", tag, ALUOp);
        end
    endtask

    // Apply an opcode on the falling edge, check its decode after the next
    // rising edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [9:0] exp);
        @(negedge clk);
        Opcode = op;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        // reset held with R-type on the input while the clock runs
        rst_n  = 1'b0;
        Opcode = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", EXP_ZERO);

        // release with lw present: first edge loads lw
        @(negedge clk);
        Opcode = 6'b100011;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        check("lw", EXP_LW);

        step("sw",      6'b101011, EXP_SW);
        step("rtype",   6'b000000, EXP_R);
        step("addi",    6'b001000, EXP_ADDI);
        step("beq",     6'b000100, EXP_BEQ);
        step("j",       6'b000010, EXP_J);
        step("ill_33",  6'b110011, EXP_ILL);
        step("ill_3f",  6'b111111, EXP_ILL);
        step("ill_21",  6'b100001, EXP_ILL);
        step("j_again", 6'b000010, EXP_J);

        // mid-stream reset: load R-type, then assert reset between edges
        step("rtype_pre", 6'b000000, EXP_R);
        @(negedge clk);
        Opcode = 6'b100011;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", EXP_ZERO);

        // an edge while reset is held must not capture the opcode
        @(posedge clk);
        #1;
        check("reset_discard", EXP_ZERO);

        // release: first edge restores the lw decode
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("lw_restore", EXP_LW);

        step("addi_post", 6'b001000, EXP_ADDI);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/main_decoder.md
MAIN_DECODER -- requirements
Module: main_decoder

Interface
REQ-001 Parameters SHALL be none; the opcode width is fixed at 6 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Opcode  input  6  instruction bits [31:26].
REQ-005 regwrite  output  1  register-file write enable.
REQ-006 regdest  output  1  destination select: 1 = rd, 0 = rt.
REQ-007 alusrc  output  1  ALU operand B select: 1 = sign-extended immediate, 0 = register.
REQ-008 memtoreg  output  1  write-back select: 1 = data memory, 0 = ALU result.
REQ-009 memwrite  output  1  data-memory write enable.
REQ-010 branch  output  1  conditional branch (beq).
REQ-011 jump  output  1  unconditional jump.
REQ-012 ALUOp  output  2  ALU class: 00 = add, 01 = subtract/compare, 10 = decode funct, 11 = unused.
REQ-013 illegal  output  1  opcode not in the supported set.

Function
REQ-014 Every output SHALL be a flip-flop output, loaded on each rising clk edge from the combinational decode of the Opcode sampled at that edge.
REQ-015 Latency SHALL be exactly one cycle, with no enable and no handshake; a new Opcode is accepted every cycle.
REQ-016 The decode table SHALL be as follows, with fields in the order regwrite, regdest, alusrc, branch, memwrite, memtoreg, jump, ALUOp, illegal:
- 000000 R-type: 1,1,0,0,0,0,0,10,0
- 100011 lw: 1,0,1,0,0,1,0,00,0
- 101011 sw: 0,0,1,0,1,0,0,00,0
- 001000 addi: 1,0,1,0,0,0,0,00,0
- 000100 beq: 0,0,0,1,0,0,0,01,0
- 000010 j: 0,0,0,0,0,0,1,00,0
- any other opcode: 0,0,0,0,0,0,0,00,1
REQ-017 Don't-care fields SHALL be driven to 0: regdest and memtoreg for sw, and every field except jump for j.
REQ-018 For any unsupported opcode (for example 110011, 111111, 100001), the block SHALL assert no architectural state change: regwrite, memwrite, branch and jump SHALL all be 0.
REQ-019 At most one of branch, jump and memwrite SHALL be 1 in any cycle.
REQ-020 ALUOp = 11 SHALL never be produced.
REQ-021 An Opcode containing X or Z bits SHALL decode as unsupported (illegal = 1, all other outputs 0) and SHALL NOT propagate X to the outputs.

Reset
REQ-022 While rst_n = 0, every output SHALL be 0 immediately and asynchronously, independent of clk.
REQ-023 illegal SHALL be 0 during reset.
REQ-024 On rst_n deassertion, the first rising clk edge SHALL load the decode of the current Opcode.
REQ-025 Asserting reset mid-stream SHALL clear all outputs in the same cycle; the Opcode present during reset SHALL be discarded.

Verification
REQ-026 The bench SHALL hold rst_n = 0 with Opcode = 000000 and toggle clk -> all outputs 0, including ALUOp = 00 and illegal = 0.
REQ-027 The bench SHALL release reset and apply lw (100011), then sw (101011), one per cycle -> one cycle later regwrite = 1, alusrc = 1, memtoreg = 1, ALUOp = 00; the next cycle memwrite = 1, alusrc = 1, regwrite = 0.
REQ-028 The bench SHALL apply R-type (000000), then addi (001000) -> regwrite = 1, regdest = 1, ALUOp = 10; then regwrite = 1, alusrc = 1, regdest = 0, ALUOp = 00.
REQ-029 The bench SHALL apply beq (000100), then j (000010) -> branch = 1, ALUOp = 01, all else 0; then jump = 1, all else 0.
REQ-030 The bench SHALL apply 110011, 111111 and 100001 -> illegal = 1 and every other output 0 for each.
REQ-031 The bench SHALL set Opcode = 100011 and assert rst_n = 0 between clk edges -> all outputs 0 before the next edge; after release, the first edge restores the lw decode.
